// File: rtl/pipe_flow_ctrl_if.sv
// +----------------------------------------------------------------------+
// | pipe_flow_ctrl_if : hazard requests in, stage flow codes out         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'b00
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'b01
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'b10
`endif

interface pipe_flow_ctrl_if;
  logic                   ld_use_i;
  logic                   md_busy_i;
  logic                   jump_i;
  logic                   mem_wait_i;
  logic                   trap_i;
  logic                   pc_hold_o;
  logic [`FLOW_WIDTH-1:0] flow_id_o;
  logic [`FLOW_WIDTH-1:0] flow_ex_o;
  logic [`FLOW_WIDTH-1:0] flow_mem_o;
  logic [`FLOW_WIDTH-1:0] flow_wb_o;
  logic                   bus_err_o;
  logic                   flushing_o;

  // Pipeline side: raises hazard requests, consumes flow codes
  modport master (
    output ld_use_i, md_busy_i, jump_i, mem_wait_i, trap_i,
    input  pc_hold_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o,
           bus_err_o, flushing_o
  );

  modport slave (
    input  ld_use_i, md_busy_i, jump_i, mem_wait_i, trap_i,
    output pc_hold_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o,
           bus_err_o, flushing_o
  );
endinterface

`default_nettype wire

// File: rtl/pipe_flow_ctrl.sv
// +----------------------------------------------------------------------+
// | pipe_flow_ctrl : priority stall/flush resolution, trap refetch       |
// | sequencing and data-memory wait timeout for the 5-stage core         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'b00
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'b01
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'b10
`endif

module pipe_flow_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipe_flow_ctrl_if.slave  bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [`FLOW_WIDTH-1:0] F_WORK = `FLOW_WORK;
  localparam logic [`FLOW_WIDTH-1:0] F_STOP = `FLOW_STOP;
  localparam logic [`FLOW_WIDTH-1:0] F_REFR = `FLOW_REFRESH;

  localparam logic [3:0]       FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT      = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1   = CNT_W'(MEM_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;

  logic [`FLOW_WIDTH-1:0] flow_id, flow_ex, flow_mem, flow_wb;
  logic                   pc_hold;
  logic                   flush_idle;
  logic                   wait_inc;

  // Flow codes are combinational so a request acts in the cycle it is raised
  always_comb begin
    flow_id  = F_WORK;
    flow_ex  = F_WORK;
    flow_mem = F_WORK;
    flow_wb  = F_WORK;
    pc_hold  = 1'b0;
    if (rst) begin
      flow_id  = F_REFR;
      flow_ex  = F_REFR;
      flow_mem = F_REFR;
      flow_wb  = F_REFR;
      pc_hold  = 1'b1;
    end else if (bus.trap_i) begin
      flow_id  = F_REFR;
      flow_ex  = F_REFR;
      flow_mem = F_REFR;
      flow_wb  = F_REFR;
    end else if (bus.mem_wait_i) begin
      flow_id  = F_STOP;
      flow_ex  = F_STOP;
      flow_mem = F_STOP;
      flow_wb  = F_REFR;
      pc_hold  = 1'b1;
    end else if (bus.md_busy_i) begin
      flow_id  = F_STOP;
      flow_ex  = F_STOP;
      flow_mem = F_REFR;
      pc_hold  = 1'b1;
    end else if (bus.jump_i) begin
      flow_id  = F_REFR;
      flow_ex  = F_REFR;
    end else if (bus.ld_use_i) begin
      flow_id  = F_STOP;
      flow_ex  = F_REFR;
      pc_hold  = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      flow_id  = F_REFR;
    end
  end

  // The refetch countdown only advances when the FLUSH row itself is selected
  assign flush_idle = !bus.mem_wait_i && !bus.md_busy_i &&
                      !bus.jump_i && !bus.ld_use_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.trap_i) begin
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d     = ST_RUN;
        flush_cnt_d = 4'd0;
      end
    end else if ((state_q == ST_FLUSH) && flush_idle) begin
      flush_cnt_d = flush_cnt_q - 4'd1;
      if (flush_cnt_q == 4'd1) begin
        state_d = ST_RUN;
      end
    end
  end

  assign wait_inc = bus.mem_wait_i && !bus.trap_i;

  // bus_err is raised on the edge where the counter lands on the limit, so
  // saturation naturally prevents a second pulse in the same episode
  always_comb begin
    wait_cnt_d = '0;
    bus_err_d  = 1'b0;
    if (wait_inc) begin
      wait_cnt_d = (wait_cnt_q == TIMEOUT) ? wait_cnt_q : wait_cnt_q + 1'b1;
      bus_err_d  = (wait_cnt_q == TIMEOUT_M1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.flow_id_o  = flow_id;
  assign bus.flow_ex_o  = flow_ex;
  assign bus.flow_mem_o = flow_mem;
  assign bus.flow_wb_o  = flow_wb;
  assign bus.pc_hold_o  = pc_hold;
  // Registered flags are masked so reset takes effect in its own cycle
  assign bus.bus_err_o  = bus_err_q && !rst;
  assign bus.flushing_o = (state_q == ST_FLUSH) && !rst;

endmodule

`default_nettype wire
